// File: rtl/ysyx_22040759_axi_mem_bridge_pkg.sv
// Shared AXI codes, FSM encodings and request bundle
// for the single-outstanding memory-to-AXI bridge.
package ysyx_22040759_axi_mem_bridge_pkg;

  localparam logic [2:0] AXI_SIZE_B = 3'd0;
  localparam logic [2:0] AXI_SIZE_H = 3'd1;
  localparam logic [2:0] AXI_SIZE_W = 3'd2;
  localparam logic [2:0] AXI_SIZE_D = 3'd3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [1:0] W_DONE = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
  } mem_req_t;

  function automatic logic [7:0] size_mask(
    input logic [2:0] size
  );
    logic [7:0] m;
    m = 8'hFF;
    unique case (1'b1)
      (size == AXI_SIZE_B): m = 8'h01;
      (size == AXI_SIZE_H): m = 8'h03;
      (size == AXI_SIZE_W): m = 8'h0F;
      default:              m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22040759_axi_strb_gen.sv
// Byte-lane placement of write data and strobe
// from transfer size and low address bits.
module ysyx_22040759_axi_strb_gen
  import ysyx_22040759_axi_mem_bridge_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [2:0]  addr_i,
  input  logic [63:0] data_i,
  output logic [7:0]  strb_o,
  output logic [63:0] data_o
);

  assign strb_o = size_mask(size_i) << addr_i;
  assign data_o = data_i << {addr_i, 3'b000};

endmodule

// File: rtl/ysyx_22040759_axi_mem_bridge.sv
// Simple memory port to AXI4 bridge, single beat,
// one transaction in flight; reads win over writes.
module ysyx_22040759_axi_mem_bridge
  import ysyx_22040759_axi_mem_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        mem_rd_addr_valid_i,
  input  logic [31:0] mem_rd_addr_i,
  input  logic [2:0]  mem_rd_size_i,
  output logic        mem_rd_data_valid_o,
  output logic [63:0] mem_rd_data_o,

  input  logic        mem_wr_addr_valid_i,
  input  logic [31:0] mem_wr_addr_i,
  input  logic [63:0] mem_wr_data_i,
  input  logic [2:0]  mem_wr_size_i,
  output logic        mem_wr_data_valid_o,

  output logic        axi_ar_valid_o,
  input  logic        axi_ar_ready_i,
  output logic [31:0] axi_ar_addr_o,
  output logic [2:0]  axi_ar_size_o,
  output logic [3:0]  axi_ar_id_o,
  output logic [7:0]  axi_ar_len_o,
  output logic [1:0]  axi_ar_burst_o,

  input  logic        axi_r_valid_i,
  output logic        axi_r_ready_o,
  input  logic [63:0] axi_r_data_i,
  input  logic [1:0]  axi_r_resp_i,
  input  logic        axi_r_last_i,
  input  logic [3:0]  axi_r_id_i,

  output logic        axi_aw_valid_o,
  input  logic        axi_aw_ready_i,
  output logic [31:0] axi_aw_addr_o,
  output logic [2:0]  axi_aw_size_o,
  output logic [3:0]  axi_aw_id_o,
  output logic [7:0]  axi_aw_len_o,
  output logic [1:0]  axi_aw_burst_o,

  output logic        axi_w_valid_o,
  input  logic        axi_w_ready_i,
  output logic [63:0] axi_w_data_o,
  output logic [7:0]  axi_w_strb_o,
  output logic        axi_w_last_o,

  input  logic        axi_b_valid_i,
  output logic        axi_b_ready_o,
  input  logic [1:0]  axi_b_resp_i,
  input  logic [3:0]  axi_b_id_i
);

  logic [1:0]  r_state_q, r_state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [2:0]  rd_size_q, rd_size_d;
  logic [63:0] rd_data_q, rd_data_d;

  logic [1:0]  w_state_q, w_state_d;
  mem_req_t    wr_req_q, wr_req_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        r_hit;
  logic        b_hit;
  logic        unused_resp;

  // error responses complete like OKAY, so resp is not inspected
  assign unused_resp = ^{axi_r_resp_i, axi_b_resp_i};

  assign r_hit = axi_r_valid_i & axi_r_last_i
               & (axi_r_id_i == AXI_ID);
  assign b_hit = axi_b_valid_i & (axi_b_id_i == AXI_ID);

  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_size_d = rd_size_q;
    rd_data_d = rd_data_q;
    case (r_state_q)
      R_IDLE: begin
        if (mem_rd_addr_valid_i && w_state_q == W_IDLE) begin
          r_state_d = R_ADDR;
          rd_addr_d = mem_rd_addr_i;
          rd_size_d = mem_rd_size_i;
        end
      end
      R_ADDR: begin
        if (axi_ar_ready_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (r_hit) begin
          rd_data_d = axi_r_data_i >> {rd_addr_q[2:0], 3'b000};
          r_state_d = R_DONE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    wr_req_d  = wr_req_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (mem_wr_addr_valid_i && !mem_rd_addr_valid_i
            && r_state_q == R_IDLE) begin
          w_state_d     = W_ADDR;
          wr_req_d.addr = mem_wr_addr_i;
          wr_req_d.size = mem_wr_size_i;
          wr_req_d.data = mem_wr_data_i;
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
        end
      end
      W_ADDR: begin
        aw_done_d = aw_done_q | axi_aw_ready_i;
        w_done_d  = w_done_q | axi_w_ready_i;
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP: begin
        if (b_hit) w_state_d = W_DONE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      rd_addr_q <= '0;
      rd_size_q <= '0;
      rd_data_q <= '0;
      w_state_q <= W_IDLE;
      wr_req_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rd_addr_q <= rd_addr_d;
      rd_size_q <= rd_size_d;
      rd_data_q <= rd_data_d;
      w_state_q <= w_state_d;
      wr_req_q  <= wr_req_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  ysyx_22040759_axi_strb_gen u_strb_gen (
    .size_i (wr_req_q.size),
    .addr_i (wr_req_q.addr[2:0]),
    .data_i (wr_req_q.data),
    .strb_o (axi_w_strb_o),
    .data_o (axi_w_data_o)
  );

  assign mem_rd_data_valid_o = (r_state_q == R_DONE);
  assign mem_rd_data_o       = rd_data_q;
  assign mem_wr_data_valid_o = (w_state_q == W_DONE);

  assign axi_ar_valid_o = (r_state_q == R_ADDR);
  assign axi_ar_addr_o  = rd_addr_q;
  assign axi_ar_size_o  = rd_size_q;
  assign axi_ar_id_o    = AXI_ID;
  assign axi_ar_len_o   = 8'd0;
  assign axi_ar_burst_o = AXI_BURST_INCR;
  assign axi_r_ready_o  = (r_state_q == R_DATA);

  assign axi_aw_valid_o = (w_state_q == W_ADDR) & ~aw_done_q;
  assign axi_aw_addr_o  = wr_req_q.addr;
  assign axi_aw_size_o  = wr_req_q.size;
  assign axi_aw_id_o    = AXI_ID;
  assign axi_aw_len_o   = 8'd0;
  assign axi_aw_burst_o = AXI_BURST_INCR;
  assign axi_w_valid_o  = (w_state_q == W_ADDR) & ~w_done_q;
  assign axi_w_last_o   = axi_w_valid_o;
  assign axi_b_ready_o  = (w_state_q == W_RESP);

endmodule
